// File: rtl/timer_pkg.sv
// timer_pkg: shared state type and default width for the down-counting timer.
//   timer_state_t : IDLE (stopped, count holds) / RUN (counting)
//   DEFAULT_WIDTH : default bit width of load_val and count
package timer_pkg;
    typedef enum logic {IDLE, RUN} timer_state_t;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/down_reg.sv
// down_reg: WIDTH-bit count register with sync reset, sync load and decrement.
//   clk  : clock
//   R    : synchronous active-high reset (clears q)
//   load : load d into q (wins over dec)
//   d    : load value
//   dec  : decrement q by one
//   q    : registered count
module down_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (R)
            q <= '0;
        else if (load)
            q <= d;
        else if (dec)
            q <= q - 1'b1;
    end
endmodule

// File: rtl/sync_down_timer.sv
// sync_down_timer: programmable down-counter/timer, one-shot or auto-reload.
//   clk         : clock
//   R           : synchronous active-high reset, highest priority
//   start       : load load_val and (re)start counting
//   load_val    : start/reload value, captured on start
//   en          : count enable; count holds when low
//   auto_reload : at terminal count, 1 = reload and continue, 0 = stop
//   count       : registered count value
//   Z           : terminal-count tick (combinational)
//   busy        : high while running
module sync_down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             Z,
    output logic             busy
);
    timer_state_t     state, state_nx;
    logic [WIDTH-1:0] reload_reg;
    logic             terminal;
    logic             load;
    logic             dec;
    logic [WIDTH-1:0] d;

    // Count 0 always takes the terminal path, so the decrement never wraps.
    assign terminal = (state == RUN) && en && (count == '0);
    assign Z        = terminal;
    assign busy     = (state == RUN);
    assign load     = start | (terminal & auto_reload);
    assign dec      = (state == RUN) & en & (count != '0);
    assign d        = start ? load_val : reload_reg;

    always_comb begin
        state_nx = start ? RUN : (terminal && !auto_reload) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state      <= IDLE;
            reload_reg <= '0;
        end else begin
            state <= state_nx;
            if (start)
                reload_reg <= load_val;
        end
    end

    down_reg #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .R    (R),
        .load (load),
        .d    (d),
        .dec  (dec),
        .q    (count)
    );
endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: directed vector table plus hand sequences for sync_down_timer.
module tb_sync_down_timer;
    logic       clk = 1'b0;
    logic       R = 1'b1;
    logic       start = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] count;
    logic       Z;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_down_timer #(.WIDTH(4)) dut (
        .clk         (clk),
        .R           (R),
        .start       (start),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .Z           (Z),
        .busy        (busy)
    );

    typedef struct {
        logic       r;
        logic       st;
        logic [3:0] lv;
        logic       en;
        logic       ar;
        logic [3:0] c;
        logic       z;
        logic       b;
        logic       chk;
    } vec_t;

    vec_t v[$];

    task automatic add(input logic r, input logic st, input logic [3:0] lv, input logic e,
                       input logic ar, input logic [3:0] c, input logic z, input logic b,
                       input logic chk);
        vec_t t;
        t.r = r; t.st = st; t.lv = lv; t.en = e; t.ar = ar;
        t.c = c; t.z = z; t.b = b; t.chk = chk;
        v.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] c, input logic z, input logic b);
        check({name, ".count"}, {4'h0, count}, {4'h0, c});
        check({name, ".Z"}, {7'h0, Z}, {7'h0, z});
        check({name, ".busy"}, {7'h0, busy}, {7'h0, b});
    endtask

    initial begin
        int n;
        // Each row: inputs held for one cycle; expected values are those visible in that cycle.
        // reset with start asserted: R wins
        add(1, 1, 5, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 0, 0, 0, 0, 0, 1);
        add(0, 0, 5, 1, 0, 0, 0, 0, 1);
        // one-shot, load_val=6
        add(0, 1, 6, 1, 0, 0, 0, 0, 1);
        for (int i = 6; i >= 1; i--) add(0, 0, 6, 1, 0, 4'(i), 0, 1, 1);
        add(0, 0, 6, 1, 0, 0, 1, 1, 1);
        add(0, 0, 6, 1, 0, 0, 0, 0, 1);
        // auto-reload, load_val=3, 12 enabled cycles -> 3 Z pulses
        add(0, 1, 3, 1, 1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            for (int i = 3; i >= 0; i--) add(0, 0, 3, 1, 1, 4'(i), i == 0, 1, 1);
        // restart from RUN with en low, then en gating 1,0,1,0,1
        add(0, 1, 2, 0, 0, 3, 0, 1, 1);
        add(0, 0, 2, 1, 0, 2, 0, 1, 1);
        add(0, 0, 2, 0, 0, 1, 0, 1, 1);
        add(0, 0, 2, 1, 0, 1, 0, 1, 1);
        add(0, 0, 2, 0, 0, 0, 0, 1, 1);
        add(0, 0, 2, 1, 0, 0, 1, 1, 1);
        // restart at count=3 with load_val=5
        add(0, 1, 4, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4, 1, 0, 4, 0, 1, 1);
        add(0, 1, 5, 1, 0, 3, 0, 1, 1);
        add(0, 0, 5, 1, 0, 5, 0, 1, 1);
        add(0, 0, 5, 1, 0, 4, 0, 1, 1);
        // load_val=0 one-shot: single Z then IDLE
        add(0, 1, 0, 1, 0, 3, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // load_val=0 auto-reload: Z every cycle, load_val change ignored, restart while Z high
        add(0, 1, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 7, 1, 1, 0, 1, 1, 1);
        add(0, 0, 7, 1, 1, 0, 1, 1, 1);
        add(0, 1, 2, 1, 1, 0, 1, 1, 1);
        add(0, 0, 2, 1, 0, 2, 0, 1, 1);
        add(0, 0, 2, 1, 0, 1, 0, 1, 1);

        foreach (v[i]) begin
            @(negedge clk);
            R = v[i].r; start = v[i].st; load_val = v[i].lv; en = v[i].en; auto_reload = v[i].ar;
            #1;
            if (v[i].chk) check_out($sformatf("vec%0d", i), v[i].c, v[i].z, v[i].b);
        end

        // reset mid-run at count=4
        @(negedge clk);
        R = 0; start = 1; load_val = 9; en = 1; auto_reload = 0;
        @(negedge clk);
        start = 0;
        n = 0;
        while (count !== 4'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_count4", {4'h0, count}, 8'h04);
        R = 1;
        @(negedge clk);
        R = 0;
        #1;
        check_out("mid_reset", 0, 0, 0);
        start = 1; load_val = 1;
        @(negedge clk);
        start = 0;
        #1;
        check_out("after_reset_1", 1, 0, 1);
        @(negedge clk);
        #1;
        check_out("after_reset_0", 0, 1, 1);
        @(negedge clk);
        #1;
        check_out("after_reset_idle", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Programmable synchronous down-counter/timer; the count-down companion to the team's up-counting synCounter.
- Loads a start value, decrements on each enabled cycle, and flags terminal count Z when the count reaches 0.
- Operates in one-shot or auto-reload mode.
- Used as an interval/timeout generator alongside the up-counters, sharing the same clk/R conventions.

Parameters:
WIDTH, 4, bit width of load_val and count

Ports:
clk  input  1  system clock; all state updates on posedge clk
R  input  1  reset, synchronous, active-high; highest priority
start  input  1  load load_val and begin counting; may be a level or a pulse
load_val  input  WIDTH  start/reload value, captured on the start edge
en  input  1  count enable; when low, count holds
auto_reload  input  1  sampled at terminal count: 1 = reload and continue, 0 = stop
count  output  WIDTH  current count value (registered)
Z  output  1  terminal-count tick, combinational
busy  output  1  high while state == RUN (registered state)

Behaviour:
- Interface: one clock (clk); reset R is synchronous and active-high, sampled only on posedge clk; no asynchronous reset path.
- Reset: R=1 at a clk edge forces state=IDLE, count=0, reload_reg=0, busy=0. Z=0 while state=IDLE.
- Priority at each edge: R > start > terminal handling > decrement > hold.
- States:
  - IDLE: count holds its last value. start=1 -> count<=load_val, reload_reg<=load_val, state<=RUN.
  - RUN, start=1: restart; same loads as from IDLE. A restart takes effect even when Z is high that cycle.
  - RUN, en=0: count, state and reload_reg hold.
  - RUN, en=1, count!=0: count<=count-1.
  - RUN, en=1, count==0 (terminal), auto_reload=1: count<=reload_reg, stay RUN.
  - RUN, en=1, count==0 (terminal), auto_reload=0: state<=IDLE, count stays 0.
- Z = (state==RUN) && (count==0) && en.
  - Exactly one Z cycle per period.
  - Period = reload_reg+1 enabled cycles, matching the up-counter's maxCount+1 period.
- load_val == 0: RUN with count=0; Z on the first enabled cycle. With auto_reload=1, Z stays high every enabled cycle (period 1).
- load_val changes while in RUN are ignored until the next start.
- Width: the decrement is modulo 2^WIDTH but never underflows, because count==0 always takes the terminal path. Maximum period is 2^WIDTH enabled cycles.
- R asserted mid-count aborts immediately: next cycle IDLE, count=0, Z=0.
- Latency: start edge -> count=load_val and busy=1 visible in the following cycle.

Decomposition:
- Package timer_pkg:
  - typedef enum logic {IDLE, RUN} timer_state_t
  - localparam DEFAULT_WIDTH = 4
- One sub-module, down_reg:
  - WIDTH-bit register with sync reset, sync load (load, d) and decrement-enable (dec).
  - Load has priority over dec.
  - The top FSM drives load = start | (terminal & auto_reload) and dec = RUN & en & count!=0.

Test Plan:
- Reset: R=1 for 2 edges with start=1 -> count=0, busy=0, Z=0. R has priority over start.
- One-shot: load_val=6, auto_reload=0, en=1, start for 1 cycle -> count 6,5,4,3,2,1,0 on successive cycles; Z=1 only in the count=0 cycle; next cycle busy=0, count=0, Z=0.
- Auto-reload: load_val=3, auto_reload=1, en=1 for 12 cycles after start -> count 3,2,1,0,3,2,1,0,3,...; Z high every 4th cycle, 3 pulses total.
- Enable gating: load_val=2; en toggles 1,0,1,0,1 -> count 2,1,1,0,0; Z=1 only in the cycle where count=0 and en=1.
- Restart and load_val=0: start again at count=3 with load_val=5 -> next count=5. start with load_val=0, en=1, auto_reload=0 -> Z=1 for one cycle, then IDLE.
- Reset mid-run: load_val=9, assert R at count=4 -> next cycle count=0, busy=0, Z=0. A subsequent start with load_val=1 counts 1,0 normally.
